periph_bus_slave: RTL and testbench
===================================

# periph_bus_slave

Memory-mapped peripheral responder for the pipelined MIPS core. It answers the core's MEM-stage load/store accesses in the 0x4000_0000 window. It owns the timer, LED, switch, and 7-segment registers and a full-duplex 8N1 UART. It drives the timer interrupt request that the core's Control unit receives as `irq`.

## Interface
- `BAUD_DIV`, 5208: clk cycles per UART bit (50 MHz / 9600); must be ≥ 4.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `rd` in 1: load strobe (MemRead in MEM stage).
- `wr` in 1: store strobe (MemWrite in MEM stage).
- `addr` in 32: byte address; bits [1:0] ignored.
- `wdata` in 32: store data.
- `rdata` out 32: load data, combinational.
- `switch` in 8: board switches.
- `led` out 8: LED register.
- `digi` out 12: 7-segment register (anode select + segments).
- `irqout` out 1: timer interrupt request, level.
- `rx` in 1: UART receive line, asynchronous.
- `tx` out 1: UART transmit line.

## Operation
- Address map, word registers:
  - 0x00 TH (rw 32)
  - 0x04 TL (rw 32)
  - 0x08 TCON (rw [2:0]: b0 enable, b1 irq enable, b2 irq status)
  - 0x0C LED (rw [7:0])
  - 0x10 SWITCH (ro [7:0])
  - 0x14 DIGI (rw [11:0])
  - 0x18 TXD (w [7:0])
  - 0x1C RXD (ro [7:0])
  - 0x20 UCON (ro: b2 tx busy, b3 rx valid, b4 rx overrun)
- All offsets are from 0x4000_0000. Unmapped addresses and unused bits read 0. Writes to read-only or unmapped addresses are ignored.
- `rdata` is 0 when `rd`=0.
- Timer:
  - While TCON.b0=1, TL increments every cycle.
  - When TL=0xFFFF_FFFF, the next edge loads TL←TH instead of incrementing. If TCON.b1=1 on that edge, TCON.b2 is also set.
  - `irqout` = TCON.b2.
  - A software write to TCON is the only way to clear b2.
  - A software write to TL on the same edge as an increment or reload: the write wins.
- UART TX, states IDLE → START → DATA(8, LSB first) → STOP → IDLE:
  - Each state or bit lasts BAUD_DIV cycles.
  - A write to TXD in IDLE latches the byte and enters START on that edge.
  - A write to TXD while busy is dropped.
  - busy = (state≠IDLE).
- UART RX:
  - `rx` passes through a 2-flop synchronizer.
  - In IDLE, a falling edge starts a BAUD_DIV/2 counter. At its expiry the line is re-sampled. If it is high, this is a false start: return to IDLE.
  - Otherwise sample 8 data bits and then the stop bit, each BAUD_DIV cycles apart.
  - Stop=1: load RXD. If valid is already 1, set overrun. Set valid.
  - Stop=0: framing error; discard the byte, no flag change.
- A load from RXD clears valid and overrun on that edge. If a new byte completes on the same edge, valid stays 1 and RXD takes the new byte.

## Timing
- Reset values:
  - TH, TL, TCON, LED, DIGI, RXD and all UART state are 0.
  - `tx`=1, `irqout`=0, `led`=0, `digi`=0.
- Reset is asynchronous. Asserting `rst` mid-frame forces `tx` high and both UART FSMs to IDLE immediately.
- Write latency: register updates on the edge where `wr`=1.
- Read latency: 0 cycles, combinational from `addr` and current state.
- TX: `tx` falls on the first edge after the TXD write. Busy lasts exactly 10×BAUD_DIV cycles.
- RX: valid rises 2 (synchronizer) + BAUD_DIV/2 + 9×BAUD_DIV cycles after the line's falling edge, ±1 cycle.
- Timer: `irqout` rises on the reload edge, 1 cycle after TL reads 0xFFFF_FFFF.

## Configuration
- `PERIPH_TIMER_EN` defined: timer registers and `irqout` behave as above.
- Undefined:
  - TH, TL and TCON read 0 and ignore writes.
  - `irqout` is tied 0.
  - No timer flops are synthesized.
  - UART, LED, switch and DIGI are unaffected.

## Test plan
- Reset:
  - Assert `rst` mid-TX-frame → `tx`=1 within the same cycle, UCON reads 0.
  - Loads from 0x4000_0008 and 0x4000_0024 return 0.
- Timer (with `PERIPH_TIMER_EN`):
  - Write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, then TCON=3 → TL=0xFFFF_FFFF next cycle.
  - The following edge: TL=0xFFFF_FFFD and `irqout`=1.
  - Writing TCON=1 drops `irqout`.
- TX with BAUD_DIV=4:
  - Write 0x55 to TXD → `tx` pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. UCON.b2=1 for 40 cycles.
  - A write of 0xFF during the frame is ignored.
- RX:
  - Drive a frame of 0xA3 at BAUD_DIV=4 → RXD=0xA3, UCON=0x08.
  - Load RXD → UCON=0x00.
  - Two frames (0x11, 0x22) without a read → RXD=0x22, UCON=0x18.
- RX false start and framing error:
  - A 1-cycle low glitch on `rx` → no valid.
  - A frame with stop bit 0 → no valid, RXD unchanged.
- GPIO:
  - switch=0x5A → load 0x4000_0010 returns 0x0000_005A.
  - Store 0x1FF to LED → `led`=0xFF.
  - Store 0xABC to DIGI → `digi`=0xABC.
  - Store to 0x4000_0010 → no effect.

Source files
------------

// File: rtl/periph_bus_slave.sv
// periph_bus_slave: memory-mapped responder for the MIPS core at 0x4000_0000.
// Hosts LED/switch/7-seg registers, a full-duplex 8N1 UART and an optional
// 32-bit reload timer that is built only when PERIPH_TIMER_EN is defined.
module periph_bus_slave #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout,
  input  logic        rx,
  output logic        tx
);
  localparam int CW = (BAUD_DIV > 4) ? $clog2(BAUD_DIV) : 2;
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  localparam logic [3:0] OFF_TH   = 4'd0;
  localparam logic [3:0] OFF_TL   = 4'd1;
  localparam logic [3:0] OFF_TCON = 4'd2;
  localparam logic [3:0] OFF_LED  = 4'd3;
  localparam logic [3:0] OFF_SW   = 4'd4;
  localparam logic [3:0] OFF_DIGI = 4'd5;
  localparam logic [3:0] OFF_TXD  = 4'd6;
  localparam logic [3:0] OFF_RXD  = 4'd7;
  localparam logic [3:0] OFF_UCON = 4'd8;

  typedef enum logic [1:0] {U_IDLE = 2'd0, U_START = 2'd1, U_DATA = 2'd2, U_STOP = 2'd3} uart_state_e;

  logic        in_win_s;
  logic [3:0]  off_s;
  logic        rx_ld_s;
  logic        tx_busy_s;
  logic        rx_fall_s;
  logic        unused_bits_s;
  logic [31:0] th_rd_s, tl_rd_s;
  logic [2:0]  tcon_rd_s;

  logic [7:0]    led_q, led_d;
  logic [11:0]   digi_q, digi_d;
  uart_state_e   tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e   rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;

  // Window decode: 64-byte block at 0x4000_0000, word-granular offsets.
  assign in_win_s      = (addr[31:6] == 26'h100_0000);
  assign off_s         = addr[5:2];
  assign rx_ld_s       = rd && in_win_s && (off_s == OFF_RXD);
  assign tx_busy_s     = (tx_st_q != U_IDLE);
  assign rx_fall_s     = rx_prev_q && !rx_s2_q;
  assign unused_bits_s = ^{wdata[31:12], addr[1:0]};

  assign led  = led_q;
  assign digi = digi_q;
  assign tx   = tx_q;

`ifdef PERIPH_TIMER_EN
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        wrap_s;

  assign wrap_s = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  // Timer next state: software writes override counting, reload and status set.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr && in_win_s && (off_s == OFF_TH)) th_d = wdata;
    else                                     th_d = th_q;
    if (wr && in_win_s && (off_s == OFF_TL)) tl_d = wdata;
    else if (wrap_s)                         tl_d = th_q;
    else if (tcon_q[0])                      tl_d = tl_q + 32'd1;
    else                                     tl_d = tl_q;
    if (wr && in_win_s && (off_s == OFF_TCON)) tcon_d = wdata[2:0];
    else if (wrap_s && tcon_q[1])              tcon_d = tcon_q | 3'b100;
    else                                       tcon_d = tcon_q;
  end

  // Timer register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'd0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_rd_s   = th_q;
  assign tl_rd_s   = tl_q;
  assign tcon_rd_s = tcon_q;
  assign irqout    = tcon_q[2];
`else
  assign th_rd_s   = 32'd0;
  assign tl_rd_s   = 32'd0;
  assign tcon_rd_s = 3'd0;
  assign irqout    = 1'b0;
`endif

  // Load data mux; zero when no load is in progress or address is unmapped.
  always_comb begin
    rdata = 32'd0;
    if (rd && in_win_s) begin
      case (off_s)
        OFF_TH:   rdata = th_rd_s;
        OFF_TL:   rdata = tl_rd_s;
        OFF_TCON: rdata = {29'd0, tcon_rd_s};
        OFF_LED:  rdata = {24'd0, led_q};
        OFF_SW:   rdata = {24'd0, switch};
        OFF_DIGI: rdata = {20'd0, digi_q};
        OFF_RXD:  rdata = {24'd0, rxd_q};
        OFF_UCON: rdata = {27'd0, rx_ovr_q, rx_valid_q, tx_busy_s, 2'b00};
        default:  rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // GPIO registers and UART transmitter next state.
  always_comb begin
    led_d    = led_q;
    digi_d   = digi_q;
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    if (wr && in_win_s && (off_s == OFF_LED))  led_d = wdata[7:0];
    else                                       led_d = led_q;
    if (wr && in_win_s && (off_s == OFF_DIGI)) digi_d = wdata[11:0];
    else                                       digi_d = digi_q;
    case (tx_st_q)
      U_IDLE: begin
        if (wr && in_win_s && (off_s == OFF_TXD)) begin
          tx_st_d  = U_START;
          tx_cnt_d = '0;
          tx_bit_d = 3'd0;
          tx_sh_d  = wdata[7:0];
          tx_d     = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      U_START: begin
        if (tx_cnt_q == FULL_LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = U_DATA;
          tx_d     = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      U_DATA: begin
        if (tx_cnt_q == FULL_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = U_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      U_STOP: begin
        if (tx_cnt_q == FULL_LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = U_IDLE;
          tx_d     = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_st_d = U_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // UART receiver: mid-bit sampling after a half-bit start qualification.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rxd_d      = rxd_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_ld_s) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
    end
    case (rx_st_q)
      U_IDLE: begin
        if (rx_fall_s) begin
          rx_st_d  = U_START;
          rx_cnt_d = '0;
        end else begin
          rx_cnt_d = '0;
        end
      end
      U_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          if (rx_s2_q) rx_st_d = U_IDLE;
          else         rx_st_d = U_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      U_DATA: begin
        if (rx_cnt_q == FULL_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = U_STOP;
          else                  rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      U_STOP: begin
        if (rx_cnt_q == FULL_LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = U_IDLE;
          if (rx_s2_q) begin
            rxd_d      = rx_sh_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ld_s) rx_ovr_d = 1'b1;
            else                        rx_ovr_d = rx_ovr_d;
          end else begin
            rxd_d = rxd_q;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        rx_st_d  = U_IDLE;
        rx_cnt_d = '0;
      end
    endcase
  end

  // GPIO and UART register bank; reset idles both FSMs and forces tx high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= 8'd0;
      digi_q     <= 12'd0;
      tx_st_q    <= U_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'd0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_st_q    <= U_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      rxd_q      <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      led_q      <= led_d;
      digi_q     <= digi_d;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rxd_q      <= rxd_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end
endmodule

// File: tb/tb_periph_bus_slave.sv
// Self-checking bench for periph_bus_slave at BAUD_DIV=4.
// Expectations come from a small behavioural model of the register map.
module tb_periph_bus_slave;
  localparam int BD = 4;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TXD  = 32'h4000_0018;
  localparam logic [31:0] A_RXD  = 32'h4000_001C;
  localparam logic [31:0] A_UCON = 32'h4000_0020;
  localparam logic [31:0] A_NONE = 32'h4000_0024;

  logic        clk = 1'b0;
  logic        rst, rd, wr, rx, irqout, tx;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  sw, led;
  logic [11:0] digi;

  int errors = 0;
  int checks = 0;

  // receiver model state
  logic [7:0] m_rxd = 8'd0;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;

  always #5 clk = ~clk;

  periph_bus_slave #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(sw), .led(led), .digi(digi), .irqout(irqout),
    .rx(rx), .tx(tx)
  );

  // All bus tasks are entered on a falling edge and return on the next one.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a; #1; d = rdata;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BD) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  function automatic logic [31:0] ucon_model();
    return {27'd0, m_ovr, m_valid, 3'b000};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irqout); end
    checks++; if (led !== 8'd0 || digi !== 12'd0) begin errors++; $display("FAIL reset_gpio led=%h digi=%h exp=0", led, digi); end
    bus_read(A_TCON, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_tcon got=%h exp=0", d); end
    bus_read(A_NONE, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", d); end
    rd = 1'b0; addr = A_UCON; #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rd_low_rdata got=%h exp=0", rdata); end
    @(negedge clk);
    // reset in the middle of a transmit frame
    bus_write(A_TXD, 32'h0000_0000);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1; #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_midframe_tx got=%b exp=1", tx); end
    rd = 1'b1; addr = A_UCON; #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_midframe_ucon got=%h exp=0", rdata); end
    rd = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gpio();
    logic [31:0] d, v;
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
    bus_write(A_LED, 32'h0000_01FF);
    checks++; if (led !== 8'hFF) begin errors++; $display("FAIL led_1ff got=%h exp=ff", led); end
    bus_write(A_DIGI, 32'h0000_0ABC);
    checks++; if (digi !== 12'hABC) begin errors++; $display("FAIL digi_abc got=%h exp=abc", digi); end
    sw = 8'h5A;
    bus_read(A_SW, d);
    checks++; if (d !== 32'h0000_005A) begin errors++; $display("FAIL switch_5a got=%h exp=5a", d); end
    for (int i = 0; i < 4; i++) begin
      v = $urandom; exp_led = v[7:0];
      bus_write(A_LED, v);
      v = $urandom; exp_digi = v[11:0];
      bus_write(A_DIGI, v);
      sw = 8'($urandom);
      bus_write(A_SW, $urandom);
      bus_read(A_LED, d);
      checks++; if (d !== {24'd0, exp_led} || led !== exp_led) begin errors++; $display("FAIL led_rand got=%h/%h exp=%h", d, led, exp_led); end
      bus_read(A_DIGI, d);
      checks++; if (d !== {20'd0, exp_digi} || digi !== exp_digi) begin errors++; $display("FAIL digi_rand got=%h/%h exp=%h", d, digi, exp_digi); end
      bus_read(A_SW, d);
      checks++; if (d !== {24'd0, sw}) begin errors++; $display("FAIL switch_rand got=%h exp=%h", d, sw); end
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0] bits;
    int bad_tx, bad_busy;
    bits = {1'b1, b, 1'b0};
    bad_tx = 0; bad_busy = 0;
    bus_write(A_TXD, {24'd0, b});
    for (int i = 0; i < 10 * BD; i++) begin
      rd = 1'b1; addr = A_UCON; wr = 1'b0;
      if (inject && i == 10) begin rd = 1'b0; wr = 1'b1; addr = A_TXD; wdata = 32'h0000_00FF; end
      #1;
      if (tx !== bits[i / BD]) bad_tx++;
      if (!(inject && i == 10) && rdata[2] !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    wr = 1'b0; rd = 1'b1; addr = A_UCON; #1;
    checks++; if (bad_tx != 0) begin errors++; $display("FAIL tx_bits byte=%h wrong_samples=%0d exp=0", b, bad_tx); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL tx_busy_len byte=%h low_samples=%0d exp=0", b, bad_busy); end
    checks++; if (rdata[2] !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL tx_end busy=%b tx=%b exp=0/1", rdata[2], tx); end
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx();
    tx_frame(8'h55, 1'b1);
    tx_frame(8'($urandom), 1'b0);
    tx_frame(8'($urandom), 1'b1);
  endtask

  task automatic rx_read_check(input string nm);
    logic [31:0] d;
    bus_read(A_UCON, d);
    checks++; if (d !== ucon_model()) begin errors++; $display("FAIL %s_ucon got=%h exp=%h", nm, d, ucon_model()); end
    bus_read(A_RXD, d);
    checks++; if (d !== {24'd0, m_rxd}) begin errors++; $display("FAIL %s_rxd got=%h exp=%h", nm, d, m_rxd); end
    m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop_bit);
    send_frame(b, stop_bit);
    if (stop_bit) begin
      m_ovr = m_ovr | m_valid; m_valid = 1'b1; m_rxd = b;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rx();
    logic [31:0] d;
    int lat;
    lat = -1;
    fork
      send_frame(8'hA3, 1'b1);
      begin
        rd = 1'b1; addr = A_UCON;
        for (int c = 0; c < 60; c++) begin
          #1; if (rdata[3] === 1'b1 && lat < 0) lat = c;
          @(negedge clk);
        end
        rd = 1'b0;
      end
    join
    m_valid = 1'b1; m_rxd = 8'hA3;
    checks++; if (lat < 39 || lat > 42) begin errors++; $display("FAIL rx_latency got=%0d exp=39..42", lat); end
    rx_read_check("rx_a3");
    bus_read(A_UCON, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rx_cleared_ucon got=%h exp=0", d); end
    rx_byte(8'h11, 1'b1);
    rx_byte(8'h22, 1'b1);
    rx_read_check("rx_overrun");
    for (int i = 0; i < 3; i++) begin
      rx_byte(8'($urandom), 1'b1);
      rx_read_check("rx_rand");
    end
    // single-cycle glitch is a false start
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_UCON, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rx_glitch_ucon got=%h exp=0", d); end
    // framing error leaves flags and data alone
    rx_byte(8'($urandom), 1'b0);
    rx_read_check("rx_framing");
  endtask

  task automatic test_timer();
    logic [31:0] d, th0, tl0, x, exp_tl;
    int k, n;
`ifdef PERIPH_TIMER_EN
    bus_write(A_TH, 32'hFFFF_FFFD);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h0000_0003);
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tmr_tl0 got=%h exp=fffffffe", d); end
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFF_FFFF || irqout !== 1'b0) begin errors++; $display("FAIL tmr_tl1 got=%h irq=%b exp=ffffffff/0", d, irqout); end
    #1;
    checks++; if (irqout !== 1'b1) begin errors++; $display("FAIL tmr_irq_rise got=%b exp=1", irqout); end
    bus_read(A_TL, d);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL tmr_reload got=%h exp=fffffffd", d); end
    bus_read(A_TCON, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL tmr_tcon got=%h exp=7", d); end
    bus_write(A_TCON, 32'h0000_0001);
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL tmr_irq_clear got=%b exp=0", irqout); end
    for (int r = 0; r < 3; r++) begin
      th0 = $urandom_range(32'h0FFF_FFFF, 0);
      k = $urandom_range(6, 0);
      n = $urandom_range(15, 2);
      tl0 = 32'hFFFF_FFFF - k;
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH, th0);
      bus_write(A_TL, tl0);
      bus_write(A_TCON, 32'd1);
      repeat (n) @(negedge clk);
      exp_tl = (n <= k) ? tl0 + n : th0 + (n - k - 1);
      bus_read(A_TL, d);
      checks++; if (d !== exp_tl || irqout !== 1'b0) begin errors++; $display("FAIL tmr_count got=%h irq=%b exp=%h/0", d, irqout, exp_tl); end
      x = $urandom;
      bus_write(A_TL, x);
      bus_read(A_TL, d);
      checks++; if (d !== x) begin errors++; $display("FAIL tmr_write_wins got=%h exp=%h", d, x); end
    end
    bus_write(A_TCON, 32'd0);
`else
    bus_write(A_TH, $urandom);
    bus_write(A_TL, $urandom);
    bus_write(A_TCON, 32'h0000_0007);
    repeat (3) @(negedge clk);
    bus_read(A_TH, d); th0 = d;
    bus_read(A_TL, d); tl0 = d;
    bus_read(A_TCON, d);
    checks++; if (th0 !== 32'd0 || tl0 !== 32'd0 || d !== 32'd0) begin errors++; $display("FAIL tmr_absent th=%h tl=%h tcon=%h exp=0", th0, tl0, d); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL tmr_absent_irq got=%b exp=0", irqout); end
    x = 32'd0; exp_tl = 32'd0; k = 0; n = 0;
`endif
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    sw = 8'd0; rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_gpio();
    test_tx();
    test_rx();
    test_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
